// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 16-bit pipelined CPU.
// Owns the PC, issues requests to a variable-latency instruction memory and
// holds the IF/ID register feeding decode. A one-entry skid buffer catches
// a word that returns while decode is stalled.
// Optional build macro: FETCH_PERF_CNT_EN enables the fetched-instruction
// counter on perf_fetch_cnt; otherwise that port is tied to zero.
//
// state   | meaning
// --------+----------------------------------------------------------------
// FETCH   | request outstanding at pc; captured word goes to IF/ID or skid
// HOLD    | skid holds a word, decode stalled; no request issued
// DROP    | redirected while a request was pending; wait it out, discard data
// HALTED  | HALT opcode delivered or odd redirect; no request until redirect

module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall_in,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr_out,
  output logic [15:0] pc_plus2_out,
  output logic        valid_out,
  output logic        halted,
  output logic        err,
  output logic [15:0] perf_fetch_cnt
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HOLD   = 2'd1,
    S_DROP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic [15:0] r_instr, w_instr_nxt;
  logic [15:0] r_pc2, w_pc2_nxt;
  logic        r_valid, w_valid_nxt;
  logic [15:0] r_skid_instr, w_skid_instr_nxt;
  logic [15:0] r_skid_pc2, w_skid_pc2_nxt;
  logic        r_skid_valid, w_skid_valid_nxt;
  logic [15:0] r_drop_addr, w_drop_addr_nxt;
  logic        r_err, w_err_nxt;

  logic        w_req;
  logic [15:0] w_addr;
  logic [15:0] w_pc_inc;
  logic        w_rdata_halt;
  logic        w_skid_halt;

  assign w_pc_inc     = r_pc + 16'd2;
  assign w_rdata_halt = (imem_rdata[15:11] == 5'b00000);
  assign w_skid_halt  = (r_skid_instr[15:11] == 5'b00000);

  // State register and all pipeline/skid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_instr      <= NOP_INSTR;
      r_pc2        <= 16'h0000;
      r_valid      <= 1'b0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc2   <= 16'h0000;
      r_skid_valid <= 1'b0;
      r_drop_addr  <= RESET_PC;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_instr      <= w_instr_nxt;
      r_pc2        <= w_pc2_nxt;
      r_valid      <= w_valid_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc2   <= w_skid_pc2_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_drop_addr  <= w_drop_addr_nxt;
      r_err        <= w_err_nxt;
    end
  end

  // Next-state, memory request and IF/ID update; redirect overrides last.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_instr_nxt      = r_instr;
    w_pc2_nxt        = r_pc2;
    w_valid_nxt      = r_valid;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc2_nxt   = r_skid_pc2;
    w_skid_valid_nxt = r_skid_valid;
    w_drop_addr_nxt  = r_drop_addr;
    w_err_nxt        = 1'b0;
    w_req            = 1'b0;
    w_addr           = r_pc;

    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (imem_ready) begin
          if (!stall_in) begin
            w_instr_nxt = imem_rdata;
            w_pc2_nxt   = w_pc_inc;
            w_valid_nxt = 1'b1;
            if (w_rdata_halt) begin
              w_state_nxt = S_HALTED;
            end else begin
              w_pc_nxt = w_pc_inc;
            end
          end else begin
            // Decode is stalled: park the word, stop requesting until it drains.
            w_skid_instr_nxt = imem_rdata;
            w_skid_pc2_nxt   = w_pc_inc;
            w_skid_valid_nxt = 1'b1;
            w_state_nxt      = S_HOLD;
            if (!w_rdata_halt) begin
              w_pc_nxt = w_pc_inc;
            end
          end
        end else if (!stall_in) begin
          w_valid_nxt = 1'b0;
          w_instr_nxt = NOP_INSTR;
        end
      end
      S_HOLD: begin
        if (!stall_in) begin
          if (r_skid_valid) begin
            w_instr_nxt = r_skid_instr;
            w_pc2_nxt   = r_skid_pc2;
            w_valid_nxt = 1'b1;
          end else begin
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP_INSTR;
          end
          w_skid_valid_nxt = 1'b0;
          w_state_nxt = (r_skid_valid && w_skid_halt) ? S_HALTED : S_FETCH;
        end
      end
      S_DROP: begin
        // The memory still owes data for the old address; keep asking for it.
        w_req  = 1'b1;
        w_addr = r_drop_addr;
        if (!stall_in) begin
          w_valid_nxt = 1'b0;
          w_instr_nxt = NOP_INSTR;
        end
        if (imem_ready) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_HALTED: begin
        if (!stall_in) begin
          w_valid_nxt = 1'b0;
          w_instr_nxt = NOP_INSTR;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase

    if (redirect_en) begin
      w_pc_nxt         = {redirect_pc[15:1], 1'b0};
      w_valid_nxt      = 1'b0;
      w_instr_nxt      = NOP_INSTR;
      w_skid_valid_nxt = 1'b0;
      if (redirect_pc[0]) begin
        w_err_nxt   = 1'b1;
        w_state_nxt = S_HALTED;
      end else if (w_req && !imem_ready) begin
        // A second redirect while already dropping keeps the original address.
        w_state_nxt = S_DROP;
        if (r_state == S_FETCH) begin
          w_drop_addr_nxt = r_pc;
        end
      end else begin
        w_state_nxt = S_FETCH;
      end
    end
  end

  assign imem_req     = w_req;
  assign imem_addr    = w_addr;
  assign instr_out    = r_instr;
  assign pc_plus2_out = r_pc2;
  assign valid_out    = r_valid;
  assign halted       = (r_state == S_HALTED);
  assign err          = r_err;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_perf_cnt;
  logic        w_load_ifid;

  assign w_load_ifid = !redirect_en && !stall_in &&
                       (((r_state == S_FETCH) && imem_ready) ||
                        ((r_state == S_HOLD) && r_skid_valid));

  // Counts every valid word entering IF/ID, even ones later flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_cnt <= 16'h0000;
    end else if (w_load_ifid) begin
      r_perf_cnt <= r_perf_cnt + 16'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_cnt;
`else
  assign perf_fetch_cnt = 16'h0000;
`endif

endmodule
